// File: rtl/vr_burst_source.sv
// Valid/ready burst transmitter: emits len incrementing words starting at seed,
// with an optional idle gap after each accepted word, honouring backpressure.
module vr_burst_source #(
    parameter int WIDTH   = 7,
    parameter int MAX_LEN = 16,
    parameter int GAP_W   = 4,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] seed,
    input  logic [GAP_W-1:0] gap,
    output logic             up_valid,
    input  logic             up_ready,
    output logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] sent_cnt
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t           state_q, state_d;
    logic             up_valid_q, up_valid_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] sent_cnt_q, sent_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             accept;

    assign accept = up_valid_q & up_ready;

    always_comb begin
        state_d    = state_q;
        up_valid_d = up_valid_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sent_cnt_d = sent_cnt_q;
        len_d      = len_q;
        gap_d      = gap_q;
        gap_cnt_d  = gap_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sent_cnt_d = '0;
                    if (len != '0) begin
                        len_d      = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
                        gap_d      = gap;
                        wr_data_d  = seed;
                        up_valid_d = 1'b1;
                        busy_d     = 1'b1;
                        state_d    = SEND;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (accept) begin
                    if (sent_cnt_q + 1'b1 == len_q) begin
                        sent_cnt_d = len_q;
                        up_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        sent_cnt_d = sent_cnt_q + 1'b1;
                        wr_data_d  = wr_data_q + 1'b1;
                        if (gap_q != '0) begin
                            up_valid_d = 1'b0;
                            gap_cnt_d  = gap_q;
                            state_d    = GAP;
                        end
                    end
                end
            end
            GAP: begin
                // Re-raising valid on the count of 1 yields exactly gap_q idle cycles.
                gap_cnt_d = gap_cnt_q - 1'b1;
                if (gap_cnt_q == GAP_W'(1)) begin
                    up_valid_d = 1'b1;
                    state_d    = SEND;
                end
            end
            default: begin
                state_d    = IDLE;
                up_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            up_valid_q <= 1'b0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sent_cnt_q <= '0;
            len_q      <= '0;
            gap_q      <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            up_valid_q <= up_valid_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sent_cnt_q <= sent_cnt_d;
            len_q      <= len_d;
            gap_q      <= gap_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign up_valid = up_valid_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sent_cnt = sent_cnt_q;

endmodule

// File: tb/tb_vr_burst_source.sv
// Directed bench for vr_burst_source; inputs change and outputs are sampled on the falling edge.
module tb_vr_burst_source;

    localparam int WIDTH   = 7;
    localparam int MAX_LEN = 16;
    localparam int GAP_W   = 4;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [WIDTH-1:0] seed;
    logic [GAP_W-1:0] gap;
    logic             up_valid;
    logic             up_ready;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] sent_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vr_burst_source #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .GAP_W(GAP_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .seed(seed), .gap(gap),
        .up_valid(up_valid), .up_ready(up_ready), .wr_data(wr_data),
        .busy(busy), .done(done), .sent_cnt(sent_cnt)
    );

    // Issue a start in the current cycle; the next falling edge is cycle 1.
    task automatic kick(input int l, input int s, input int g);
        start = 1'b1;
        len   = LEN_W'(l);
        seed  = WIDTH'(s);
        gap   = GAP_W'(g);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; up_ready = 1'b1; len = 5'd4; seed = 7'd9; gap = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({up_valid, busy, done, sent_cnt, wr_data} !== '0) begin
                bad++;
                $display("FAIL reset c%0d: v=%b b=%b d=%b cnt=%0d data=%0d required all 0",
                         c, up_valid, busy, done, sent_cnt, wr_data);
            end
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        up_ready = 1'b1;
        kick(4, 5, 0);
        for (int c = 1; c <= 4; c++) begin
            total++;
            if (up_valid !== 1'b1 || wr_data !== WIDTH'(4 + c) || busy !== 1'b1) begin
                bad++;
                $display("FAIL b2b c%0d: v=%b data=%0d busy=%b required v=1 data=%0d busy=1",
                         c, up_valid, wr_data, busy, 4 + c);
            end
            @(negedge clk);
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || up_valid !== 1'b0 || sent_cnt !== 5'd4) begin
            bad++;
            $display("FAIL b2b_done: d=%b b=%b v=%b cnt=%0d required d=1 b=0 v=0 cnt=4",
                     done, busy, up_valid, sent_cnt);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done_pulse: d=%b required 0", done);
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] rdy = 6'b110100;  // bit c-1 is up_ready in cycle c
        int exp_d[6] = '{10, 10, 10, 11, 11, 12};
        int exp_c[6] = '{0, 0, 0, 1, 1, 2};
        up_ready = 1'b0;
        kick(3, 10, 0);
        for (int c = 1; c <= 6; c++) begin
            up_ready = rdy[c-1];
            total++;
            if (up_valid !== 1'b1 || wr_data !== WIDTH'(exp_d[c-1]) || sent_cnt !== LEN_W'(exp_c[c-1])) begin
                bad++;
                $display("FAIL bp c%0d: v=%b data=%0d cnt=%0d required v=1 data=%0d cnt=%0d",
                         c, up_valid, wr_data, sent_cnt, exp_d[c-1], exp_c[c-1]);
            end
            @(negedge clk);
        end
        up_ready = 1'b1;
        total++;
        if (done !== 1'b1 || up_valid !== 1'b0 || sent_cnt !== 5'd3) begin
            bad++;
            $display("FAIL bp_done: d=%b v=%b cnt=%0d required d=1 v=0 cnt=3", done, up_valid, sent_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_gap_wrap();
        logic [6:0] vpat = 7'b1001001;  // bit c-1 is expected up_valid in cycle c
        int exp_d[7] = '{126, 0, 0, 127, 0, 0, 0};
        up_ready = 1'b1;
        kick(3, 126, 2);
        for (int c = 1; c <= 7; c++) begin
            total++;
            if (up_valid !== vpat[c-1] || (vpat[c-1] && wr_data !== WIDTH'(exp_d[c-1])) || busy !== 1'b1) begin
                bad++;
                $display("FAIL gap c%0d: v=%b data=%0d busy=%b required v=%b data=%0d busy=1",
                         c, up_valid, wr_data, busy, vpat[c-1], exp_d[c-1]);
            end
            @(negedge clk);
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || sent_cnt !== 5'd3) begin
            bad++;
            $display("FAIL gap_done: d=%b b=%b cnt=%0d required d=1 b=0 cnt=3", done, busy, sent_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_and_busy_start();
        up_ready = 1'b1;
        kick(0, 50, 0);
        total++;
        if (done !== 1'b1 || up_valid !== 1'b0 || busy !== 1'b0 || sent_cnt !== 5'd0) begin
            bad++;
            $display("FAIL zero_len: d=%b v=%b b=%b cnt=%0d required d=1 v=0 b=0 cnt=0",
                     done, up_valid, busy, sent_cnt);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || up_valid !== 1'b0) begin
            bad++;
            $display("FAIL zero_len_after: d=%b v=%b required d=0 v=0", done, up_valid);
        end
        kick(5, 20, 0);
        for (int c = 1; c <= 5; c++) begin
            if (c == 2) begin
                start = 1'b1; len = 5'd2; seed = 7'd99;
            end else begin
                start = 1'b0;
            end
            total++;
            if (up_valid !== 1'b1 || wr_data !== WIDTH'(19 + c) || done !== 1'b0) begin
                bad++;
                $display("FAIL busy_start c%0d: v=%b data=%0d d=%b required v=1 data=%0d d=0",
                         c, up_valid, wr_data, done, 19 + c);
            end
            @(negedge clk);
        end
        start = 1'b0;
        total++;
        if (done !== 1'b1 || sent_cnt !== 5'd5 || up_valid !== 1'b0) begin
            bad++;
            $display("FAIL busy_start_done: d=%b cnt=%0d v=%b required d=1 cnt=5 v=0", done, sent_cnt, up_valid);
        end
        @(negedge clk);
        total++;
        if (up_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_start_ignored: v=%b b=%b required v=0 b=0", up_valid, busy);
        end
    endtask

    task automatic test_clamp();
        up_ready = 1'b1;
        kick(31, 0, 0);
        for (int c = 1; c <= 16; c++) begin
            total++;
            if (up_valid !== 1'b1 || wr_data !== WIDTH'(c - 1)) begin
                bad++;
                $display("FAIL clamp c%0d: v=%b data=%0d required v=1 data=%0d", c, up_valid, wr_data, c - 1);
            end
            @(negedge clk);
        end
        total++;
        if (done !== 1'b1 || sent_cnt !== 5'd16 || up_valid !== 1'b0) begin
            bad++;
            $display("FAIL clamp_done: d=%b cnt=%0d v=%b required d=1 cnt=16 v=0", done, sent_cnt, up_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        up_ready = 1'b1;
        kick(8, 40, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;  // cycle 3: third word accepted on this edge, reset wins
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({up_valid, busy, done, sent_cnt, wr_data} !== '0) begin
            bad++;
            $display("FAIL mid_reset: v=%b b=%b d=%b cnt=%0d data=%0d required all 0",
                     up_valid, busy, done, sent_cnt, wr_data);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || up_valid !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_quiet c%0d: d=%b v=%b required 0 0", c, done, up_valid);
            end
        end
        kick(2, 1, 0);
        for (int c = 1; c <= 2; c++) begin
            total++;
            if (up_valid !== 1'b1 || wr_data !== WIDTH'(c) || sent_cnt !== LEN_W'(c - 1)) begin
                bad++;
                $display("FAIL post_reset c%0d: v=%b data=%0d cnt=%0d required v=1 data=%0d cnt=%0d",
                         c, up_valid, wr_data, sent_cnt, c, c - 1);
            end
            @(negedge clk);
        end
        total++;
        if (done !== 1'b1 || sent_cnt !== 5'd2) begin
            bad++;
            $display("FAIL post_reset_done: d=%b cnt=%0d required d=1 cnt=2", done, sent_cnt);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; up_ready = 1'b0; len = '0; seed = '0; gap = '0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_gap_wrap();
        test_zero_and_busy_start();
        test_clamp();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
